cdb_rr_arbiter: RTL and testbench

//  Responder end of the common data bus (CDB) handshake. Collects the result requests from all execution units and

---
 rtl/cdb_rr_arbiter_pkg.sv | 36 +++
 rtl/cdb_rr_arbiter_if.sv | 21 ++
 rtl/cdb_rr_arbiter_rr_arbiter.sv | 32 +++
 rtl/cdb_rr_arbiter.sv | 78 +++++++
 tb/tb_cdb_rr_arbiter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cdb_rr_arbiter_pkg.sv
// Shared types for the CDB responder: result payload, exception codes, requester index.
// Optional statistics counters in cdb_rr_arbiter are enabled with CDB_ARB_STATS_EN.
package cdb_rr_arbiter_pkg;

    localparam int CDB_N_EU  = 4;
    localparam int ROB_IDX_W = 5;
    localparam int XLEN      = 32;
    localparam int FLAGS_W   = 5;

    typedef enum logic [3:0] {
        E_INSTR_MISALIGNED    = 4'd0,
        E_INSTR_ACCESS_FAULT  = 4'd1,
        E_ILLEGAL_INSTRUCTION = 4'd2,
        E_BREAKPOINT          = 4'd3,
        E_LOAD_MISALIGNED     = 4'd4,
        E_LOAD_ACCESS_FAULT   = 4'd5,
        E_STORE_MISALIGNED    = 4'd6,
        E_STORE_ACCESS_FAULT  = 4'd7
    } except_code_t;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [XLEN-1:0]      res_value;
        logic                 except_raised;
        except_code_t         except_code;
        logic [FLAGS_W-1:0]   flags;
    } cdb_data_t;

    typedef logic [$clog2(CDB_N_EU)-1:0] cdb_eu_idx_t;

    // Modulo-n wrap for a value known to be below 2*n.
    function automatic int unsigned rr_wrap(input int unsigned k, input int unsigned n);
        return (k >= n) ? k - n : k;
    endfunction

endpackage

// File: rtl/cdb_rr_arbiter_if.sv
// CDB handshake bundle: per-EU request/grant/data on one side, ROB broadcast on the other.
interface cdb_rr_arbiter_if import cdb_rr_arbiter_pkg::*; #(
    parameter int N_EU = CDB_N_EU
);
    logic      [N_EU-1:0] eu_valid_i;
    logic      [N_EU-1:0] eu_ready_o;
    cdb_data_t [N_EU-1:0] eu_data_i;
    logic                 rob_ready_i;
    logic                 cdb_valid_o;
    cdb_data_t            cdb_data_o;

    modport slave (
        input  eu_valid_i, eu_data_i, rob_ready_i,
        output eu_ready_o, cdb_valid_o, cdb_data_o
    );

    modport master (
        output eu_valid_i, eu_data_i, rob_ready_i,
        input  eu_ready_o, cdb_valid_o, cdb_data_o
    );
endinterface

// File: rtl/cdb_rr_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
// Kept free of CDB specifics so the issue stage can reuse it.
module rr_arbiter import cdb_rr_arbiter_pkg::*; #(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);
    logic        found;
    int unsigned k;

    // gnt_idx is reported even when en is low; only gnt is gated.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        k       = 0;
        for (int i = 0; i < N; i++) begin
            k = rr_wrap(32'(ptr) + 32'(i), 32'(N));
            if (!found && req[k[IDX_W-1:0]]) begin
                found                = 1'b1;
                gnt_idx              = k[IDX_W-1:0];
                gnt[k[IDX_W-1:0]]    = en;
            end
        end
    end

endmodule

// File: rtl/cdb_rr_arbiter.sv
// CDB responder: round-robin grant across EUs into a one-entry broadcast stage.
// Define CDB_ARB_STATS_EN to add saturating grant/stall counters.
module cdb_rr_arbiter import cdb_rr_arbiter_pkg::*; #(
    parameter int N_EU = CDB_N_EU
`ifdef CDB_ARB_STATS_EN
  , parameter int STAT_CNT_W = 32
`endif
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    cdb_rr_arbiter_if.slave       bus
`ifdef CDB_ARB_STATS_EN
  , output logic [STAT_CNT_W-1:0] stat_grants_o,
    output logic [STAT_CNT_W-1:0] stat_stalls_o
`endif
);
    localparam int IDX_W = $clog2(N_EU);

    logic             out_valid;
    cdb_data_t        out_data;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] win;
    logic [N_EU-1:0]  gnt;
    logic             can_accept;
    logic             xfer;

    // Grant only depends on valid/rob_ready/flush, never on payload.
    assign can_accept = !out_valid || bus.rob_ready_i;

    rr_arbiter #(.N(N_EU)) u_rr (
        .req     (bus.eu_valid_i),
        .ptr     (rr_ptr),
        .en      (can_accept && !flush_i),
        .gnt     (gnt),
        .gnt_idx (win)
    );

    assign bus.eu_ready_o  = gnt;
    assign xfer            = |(bus.eu_valid_i & gnt);
    assign bus.cdb_valid_o = out_valid;
    assign bus.cdb_data_o  = out_data;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            rr_ptr    <= '0;
        end else if (flush_i) begin
            out_valid <= 1'b0;
            rr_ptr    <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= bus.eu_data_i[win];
            rr_ptr    <= (win == IDX_W'(N_EU - 1)) ? '0 : win + 1'b1;
        end else if (bus.rob_ready_i) begin
            out_valid <= 1'b0;
        end
    end

`ifdef CDB_ARB_STATS_EN
    logic stall;

    // A stall is any requester left ungranted this cycle, including the losers of a grant.
    assign stall = |(bus.eu_valid_i & ~gnt);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_grants_o <= '0;
            stat_stalls_o <= '0;
        end else begin
            if (xfer && !(&stat_grants_o))  stat_grants_o <= stat_grants_o + 1'b1;
            if (stall && !(&stat_stalls_o)) stat_stalls_o <= stat_stalls_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// Self-checking bench for cdb_rr_arbiter: round-robin model plus output scoreboard.
module tb_cdb_rr_arbiter;
    import cdb_rr_arbiter_pkg::*;

    localparam int N = 4;

    logic clk_i   = 1'b0;
    logic rst_ni  = 1'b0;
    logic flush_i = 1'b0;
    always #5 clk_i = ~clk_i;

    cdb_rr_arbiter_if #(.N_EU(N)) bus ();

`ifdef CDB_ARB_STATS_EN
    logic [3:0] stat_grants, stat_stalls;
`endif

    cdb_rr_arbiter #(
        .N_EU(N)
`ifdef CDB_ARB_STATS_EN
      , .STAT_CNT_W(4)
`endif
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .bus     (bus)
`ifdef CDB_ARB_STATS_EN
      , .stat_grants_o (stat_grants),
        .stat_stalls_o (stat_stalls)
`endif
    );

    int        n_chk  = 0;
    int        n_fail = 0;
    logic      m_out_valid = 1'b0;
    int        m_ptr = 0;
    cdb_data_t sb[$];

    // Reference round-robin: independent of the DUT's internal pointer.
    function automatic logic [N-1:0] model_gnt(input logic [N-1:0] v, input logic rr, input logic fl);
        logic [N-1:0] g;
        g = '0;
        if ((!m_out_valid || rr) && !fl)
            for (int i = 0; i < N; i++)
                if (v[(m_ptr + i) % N] && g == '0) g[(m_ptr + i) % N] = 1'b1;
        return g;
    endfunction

    task automatic model_adv(input logic [N-1:0] g);
        if (m_out_valid && bus.rob_ready_i && sb.size() > 0) void'(sb.pop_front());
        if (flush_i) begin
            m_out_valid = 1'b0; m_ptr = 0; sb.delete();
        end else if (g != '0) begin
            for (int k = 0; k < N; k++)
                if (g[k]) begin sb.push_back(bus.eu_data_i[k]); m_ptr = (k == N - 1) ? 0 : k + 1; end
            m_out_valid = 1'b1;
        end else if (bus.rob_ready_i) begin
            m_out_valid = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_out_valid = 1'b0; m_ptr = 0; sb.delete();
    endtask

    function automatic cdb_data_t rand_data();
        cdb_data_t d;
        d.rob_idx       = 5'($urandom);
        d.res_value     = $urandom;
        d.except_raised = 1'($urandom);
        d.except_code   = except_code_t'(4'($urandom_range(0, 7)));
        d.flags         = 5'($urandom);
        return d;
    endfunction

    task automatic drive_rand_data();
        for (int k = 0; k < N; k++) bus.eu_data_i[k] = rand_data();
    endtask

    task automatic test_reset();
        logic [N-1:0] g;
        bus.eu_valid_i = '0; bus.rob_ready_i = 1'b0; drive_rand_data();
        rst_ni = 1'b0; model_reset();
        repeat (2) @(negedge clk_i);
        n_chk++; if (bus.cdb_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.cdb_valid_o); end
        n_chk++; if (bus.cdb_data_o !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", bus.cdb_data_o); end
        n_chk++; if (bus.eu_ready_o !== '0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", bus.eu_ready_o); end
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        // one idle cycle out of reset
        @(negedge clk_i);
        g = model_gnt(bus.eu_valid_i, bus.rob_ready_i, flush_i);
        n_chk++; if (bus.eu_ready_o !== '0 || bus.cdb_valid_o !== 1'b0) begin n_fail++; $display("FAIL idle: ready=%b valid=%b want 0/0", bus.eu_ready_o, bus.cdb_valid_o); end
        model_adv(g);
        @(posedge clk_i); #1;
    endtask

    task automatic test_single();
        logic [N-1:0] g; cdb_data_t d2;
        logic [N-1:0] vals [3] = '{4'b0100, 4'b1111, 4'b0000};
        bus.rob_ready_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus.eu_valid_i = vals[c]; drive_rand_data();
            @(negedge clk_i);
            g = model_gnt(bus.eu_valid_i, bus.rob_ready_i, flush_i);
            n_chk++; if (bus.eu_ready_o !== g) begin n_fail++; $display("FAIL single_grant c%0d: got %b want %b", c, bus.eu_ready_o, g); end
            if (c == 0) begin
                d2 = bus.eu_data_i[2];
                n_chk++; if (bus.eu_ready_o !== 4'b0100) begin n_fail++; $display("FAIL single_first: got %b want 0100", bus.eu_ready_o); end
            end
            if (c == 1) begin
                n_chk++; if (bus.cdb_valid_o !== 1'b1 || bus.cdb_data_o !== d2) begin n_fail++; $display("FAIL single_out: got %b/%h want 1/%h", bus.cdb_valid_o, bus.cdb_data_o, d2); end
                n_chk++; if (bus.eu_ready_o !== 4'b1000) begin n_fail++; $display("FAIL single_ptr: got %b want 1000", bus.eu_ready_o); end
            end
            model_adv(g);
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] g;
        bus.rob_ready_i = 1'b1; bus.eu_valid_i = '1;
        for (int c = 0; c < 9; c++) begin
            drive_rand_data();
            @(negedge clk_i);
            g = model_gnt(bus.eu_valid_i, bus.rob_ready_i, flush_i);
            n_chk++; if (bus.eu_ready_o !== g) begin n_fail++; $display("FAIL rr_grant c%0d: got %b want %b", c, bus.eu_ready_o, g); end
            n_chk++; if (bus.cdb_valid_o !== m_out_valid || (m_out_valid && bus.cdb_data_o !== sb[0])) begin
                n_fail++; $display("FAIL rr_out c%0d: got %b/%h want %b", c, bus.cdb_valid_o, bus.cdb_data_o, m_out_valid); end
            model_adv(g);
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] g;
        for (int c = 0; c < 5; c++) begin
            drive_rand_data();
            bus.eu_data_i[0].rob_idx = 5'd5;
            bus.eu_valid_i  = (c == 0) ? 4'b0001 : 4'b1111;
            bus.rob_ready_i = (c == 0 || c == 4);
            @(negedge clk_i);
            g = model_gnt(bus.eu_valid_i, bus.rob_ready_i, flush_i);
            n_chk++; if (bus.eu_ready_o !== g) begin n_fail++; $display("FAIL bp_grant c%0d: got %b want %b", c, bus.eu_ready_o, g); end
            n_chk++; if (bus.cdb_valid_o !== m_out_valid || (m_out_valid && bus.cdb_data_o !== sb[0])) begin
                n_fail++; $display("FAIL bp_out c%0d: got %b/%h want %b", c, bus.cdb_valid_o, bus.cdb_data_o, m_out_valid); end
            if (c >= 1 && c <= 3) begin
                n_chk++; if (bus.eu_ready_o !== '0 || bus.cdb_data_o.rob_idx !== 5'd5) begin
                    n_fail++; $display("FAIL bp_hold c%0d: ready=%b rob_idx=%0d want 0/5", c, bus.eu_ready_o, bus.cdb_data_o.rob_idx); end
            end
            if (c == 4) begin
                n_chk++; if (bus.eu_ready_o === '0) begin n_fail++; $display("FAIL bp_release: ready=%b want nonzero", bus.eu_ready_o); end
            end
            model_adv(g);
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_flush();
        logic [N-1:0] g;
        for (int c = 0; c < 3; c++) begin
            drive_rand_data();
            bus.eu_valid_i  = (c == 0) ? 4'b0010 : 4'b1111;
            bus.rob_ready_i = (c != 1);
            flush_i         = (c == 1);
            @(negedge clk_i);
            g = model_gnt(bus.eu_valid_i, bus.rob_ready_i, flush_i);
            n_chk++; if (bus.eu_ready_o !== g) begin n_fail++; $display("FAIL flush_grant c%0d: got %b want %b", c, bus.eu_ready_o, g); end
            n_chk++; if (bus.cdb_valid_o !== m_out_valid || (m_out_valid && bus.cdb_data_o !== sb[0])) begin
                n_fail++; $display("FAIL flush_out c%0d: got %b/%h want %b", c, bus.cdb_valid_o, bus.cdb_data_o, m_out_valid); end
            if (c == 1) begin
                n_chk++; if (bus.eu_ready_o !== '0) begin n_fail++; $display("FAIL flush_noGrant: got %b want 0", bus.eu_ready_o); end
            end
            if (c == 2) begin
                n_chk++; if (bus.cdb_valid_o !== 1'b0 || bus.eu_ready_o !== 4'b0001) begin
                    n_fail++; $display("FAIL flush_after: valid=%b ready=%b want 0/0001", bus.cdb_valid_o, bus.eu_ready_o); end
            end
            model_adv(g);
            @(posedge clk_i); #1;
        end
        flush_i = 1'b0;
    endtask

    task automatic test_exception();
        logic [N-1:0] g; cdb_data_t d1;
        for (int c = 0; c < 2; c++) begin
            drive_rand_data();
            bus.rob_ready_i = 1'b1;
            if (c == 0) begin
                bus.eu_data_i[1].except_raised = 1'b1;
                bus.eu_data_i[1].except_code   = E_ILLEGAL_INSTRUCTION;
                bus.eu_data_i[1].flags         = 5'b10110;
                d1 = bus.eu_data_i[1];
            end
            bus.eu_valid_i = (c == 0) ? 4'b0010 : 4'b0000;
            @(negedge clk_i);
            g = model_gnt(bus.eu_valid_i, bus.rob_ready_i, flush_i);
            n_chk++; if (bus.eu_ready_o !== g) begin n_fail++; $display("FAIL exc_grant c%0d: got %b want %b", c, bus.eu_ready_o, g); end
            if (c == 1) begin
                n_chk++; if (bus.cdb_valid_o !== 1'b1 || bus.cdb_data_o.except_raised !== 1'b1 ||
                             bus.cdb_data_o.except_code !== E_ILLEGAL_INSTRUCTION || bus.cdb_data_o !== d1) begin
                    n_fail++; $display("FAIL exc_pass: got %b/%h want 1/%h", bus.cdb_valid_o, bus.cdb_data_o, d1); end
            end
            model_adv(g);
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_random();
        logic [N-1:0] g;
        for (int c = 0; c < 400; c++) begin
            drive_rand_data();
            bus.eu_valid_i  = 4'($urandom);
            bus.rob_ready_i = ($urandom_range(0, 3) != 0);
            flush_i         = ($urandom_range(0, 29) == 0);
            @(negedge clk_i);
            g = model_gnt(bus.eu_valid_i, bus.rob_ready_i, flush_i);
            n_chk++; if (bus.eu_ready_o !== g) begin n_fail++; $display("FAIL rand_grant c%0d: got %b want %b", c, bus.eu_ready_o, g); end
            n_chk++; if (bus.cdb_valid_o !== m_out_valid || (m_out_valid && bus.cdb_data_o !== sb[0])) begin
                n_fail++; $display("FAIL rand_out c%0d: got %b/%h want %b", c, bus.cdb_valid_o, bus.cdb_data_o, m_out_valid); end
            model_adv(g);
            @(posedge clk_i); #1;
        end
        flush_i = 1'b0;
    endtask

    task automatic test_async_reset();
        bus.eu_valid_i = 4'b0100; bus.rob_ready_i = 1'b1; drive_rand_data();
        @(posedge clk_i); #1;
        bus.eu_valid_i = '0;
        @(negedge clk_i);
        n_chk++; if (bus.cdb_valid_o !== 1'b1) begin n_fail++; $display("FAIL arst_pre: valid=%b want 1", bus.cdb_valid_o); end
        #2 rst_ni = 1'b0;
        #1;
        n_chk++; if (bus.cdb_valid_o !== 1'b0 || bus.cdb_data_o !== '0) begin
            n_fail++; $display("FAIL arst_mid: got %b/%h want 0/0", bus.cdb_valid_o, bus.cdb_data_o); end
        model_reset();
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_stats();
`ifdef CDB_ARB_STATS_EN
        rst_ni = 1'b0; bus.eu_valid_i = '0; flush_i = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1; model_reset();
        bus.rob_ready_i = 1'b1; bus.eu_valid_i = 4'b0001;
        repeat (20) begin drive_rand_data(); @(posedge clk_i); #1; end
        bus.eu_valid_i = '0;
        @(negedge clk_i);
        n_chk++; if (stat_grants !== 4'd15) begin n_fail++; $display("FAIL stat_sat: grants=%0d want 15", stat_grants); end
        n_chk++; if (stat_stalls !== 4'd0) begin n_fail++; $display("FAIL stat_nostall: stalls=%0d want 0", stat_stalls); end
        @(posedge clk_i); #1;
        bus.eu_valid_i = 4'b0011;
        @(posedge clk_i); #1;
        bus.eu_valid_i = '0;
        @(negedge clk_i);
        n_chk++; if (stat_stalls !== 4'd1) begin n_fail++; $display("FAIL stat_stall: stalls=%0d want 1", stat_stalls); end
        @(posedge clk_i); #1;
        model_reset();
        rst_ni = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_flush();
        test_exception();
        test_random();
        test_async_reset();
        test_stats();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
